// File: rtl/adder_pipe_arbiter_if.sv
// Bus interface for adder_pipe_arbiter: requester side and result side.
// master = client/consumer side, slave = the arbitrated adder pipeline.
interface adder_pipe_arbiter_if #(
  parameter int WIDTH   = 26,
  parameter int NUM_REQ = 4,
  parameter int LAT     = 6,
  parameter int IDW     = 2
) ();
  localparam int IFW = $clog2(LAT + 1);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_data;
  logic                     res_cout;
  logic [IDW-1:0]           res_id;
  logic [IFW-1:0]           inflight;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_cout, res_id, inflight
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_cout, res_id, inflight
  );
endinterface

// File: rtl/adder_pipe_arbiter.sv
// adder_pipe_arbiter: one LAT-stage pipelined WIDTH-bit adder shared by
// NUM_REQ requesters. Results return in issue order tagged with the issuing
// requester id; the whole pipe stalls when the consumer withholds res_ready.
// Build option: define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
// arbitration (no rotating pointer); default build is round-robin.
module adder_pipe_arbiter #(
  parameter int WIDTH   = 26,
  parameter int NUM_REQ = 4,
  parameter int LAT     = 6,
  parameter int IDW     = 2
) (
  input  logic                 clock0,
  input  logic                 reset,
  adder_pipe_arbiter_if.slave  bus
);
  localparam int IFW = $clog2(LAT + 1);

  logic                 adv_s;
  logic                 issue_s;
  logic                 retire_s;
  logic                 found_s;
  logic [NUM_REQ-1:0]   grant_s;
  logic [IDW-1:0]       gidx_s;
  logic [IDW-1:0]       base_s;
  logic [WIDTH-1:0]     a_sel_s;
  logic [WIDTH-1:0]     b_sel_s;
  logic [WIDTH:0]       sum_s;

  logic [LAT-1:0]       vld_r;
  logic [WIDTH-1:0]     data_r [LAT];
  logic [LAT-1:0]       cout_r;
  logic [IDW-1:0]       id_r   [LAT];
  logic [IFW-1:0]       inflight_r;

  // The pipe moves only when the tail is empty or being drained.
  assign adv_s    = !vld_r[LAT-1] | bus.res_ready;
  assign issue_s  = adv_s & found_s;
  assign retire_s = vld_r[LAT-1] & bus.res_ready;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0.
  assign base_s = {IDW{1'b0}};
`else
  logic [IDW-1:0] rr_ptr_r;

  assign base_s = rr_ptr_r;

  // Round-robin pointer moves just past the requester that transferred.
  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      rr_ptr_r <= {IDW{1'b0}};
    end else if (issue_s) begin
      rr_ptr_r <= (gidx_s == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : gidx_s + IDW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // Search from base_s upward with wrap; first valid requester wins and its operands are selected.
  always_comb begin : grant_search
    int   idx;
    logic hit;
    grant_s = {NUM_REQ{1'b0}};
    gidx_s  = {IDW{1'b0}};
    found_s = 1'b0;
    a_sel_s = {WIDTH{1'b0}};
    b_sel_s = {WIDTH{1'b0}};
    idx     = 0;
    hit     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx          = (int'(base_s) + k) % NUM_REQ;
      hit          = !found_s && bus.req_valid[idx];
      grant_s[idx] = grant_s[idx] | hit;
      gidx_s       = hit ? IDW'(idx) : gidx_s;
      a_sel_s      = hit ? bus.req_a[idx*WIDTH +: WIDTH] : a_sel_s;
      b_sel_s      = hit ? bus.req_b[idx*WIDTH +: WIDTH] : b_sel_s;
      found_s      = found_s | hit;
    end
  end

  // Stage-0 adder; a bubble cycle simply adds zeros.
  assign sum_s = {1'b0, a_sel_s} + {1'b0, b_sel_s};

  assign bus.req_ready = adv_s ? grant_s : {NUM_REQ{1'b0}};

  // Shift every stage together on advance, hold all stages on stall.
  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      vld_r  <= {LAT{1'b0}};
      cout_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        data_r[i] <= {WIDTH{1'b0}};
        id_r[i]   <= {IDW{1'b0}};
      end
    end else if (adv_s) begin
      vld_r[0]  <= issue_s;
      data_r[0] <= sum_s[WIDTH-1:0];
      cout_r[0] <= sum_s[WIDTH];
      id_r[0]   <= gidx_s;
      for (int i = 1; i < LAT; i++) begin
        vld_r[i]  <= vld_r[i-1];
        data_r[i] <= data_r[i-1];
        cout_r[i] <= cout_r[i-1];
        id_r[i]   <= id_r[i-1];
      end
    end else begin
      vld_r  <= vld_r;
      cout_r <= cout_r;
      for (int i = 0; i < LAT; i++) begin
        data_r[i] <= data_r[i];
        id_r[i]   <= id_r[i];
      end
    end
  end

  // Occupancy count: issue adds one, retire removes one, both together cancel.
  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      inflight_r <= {IFW{1'b0}};
    end else begin
      case ({issue_s, retire_s})
        2'b10:   inflight_r <= inflight_r + IFW'(1);
        2'b01:   inflight_r <= inflight_r - IFW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign bus.res_valid = vld_r[LAT-1];
  assign bus.res_data  = data_r[LAT-1];
  assign bus.res_cout  = cout_r[LAT-1];
  assign bus.res_id    = id_r[LAT-1];
  assign bus.inflight  = inflight_r;
endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// Self-checking bench for adder_pipe_arbiter: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_adder_pipe_arbiter;
  localparam int WIDTH   = 26;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 6;
  localparam int IDW     = 2;

  logic clock0 = 1'b0;
  logic reset  = 1'b0;

  adder_pipe_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LAT(LAT), .IDW(IDW)) bus ();

  adder_pipe_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LAT(LAT), .IDW(IDW)) dut (
    .clock0 (clock0),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clock0 = ~clock0;

  // Reference model: ops in issue order, each with the number of advancing
  // cycles it has spent in the pipe; it is visible once that reaches LAT.
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [IDW-1:0]   id;
    logic [7:0]       age;
  } op_t;

  op_t q[$];
  int  ptr_m = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  logic [NUM_REQ-1:0] last_rdy;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, then update the model at the edge.
  task automatic drive(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*WIDTH-1:0] a,
                       input logic [NUM_REQ*WIDTH-1:0] b, input logic rr);
    logic head_ok, adv;
    int   g;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [WIDTH:0] s;
    op_t  n;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.res_ready = rr;
    @(negedge clock0);
    head_ok = (q.size() > 0) && (q[0].age == 8'(LAT));
    adv     = !head_ok || rr;
    g       = -1;
    if (adv) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (g < 0 && v[(ptr_m + k) % NUM_REQ]) g = (ptr_m + k) % NUM_REQ;
      end
    end
    exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : NUM_REQ'(0);
    last_rdy = bus.req_ready;
    check_val("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check_val("res_valid", 64'(bus.res_valid), 64'(head_ok));
    if (head_ok) begin
      check_val("res_data", 64'(bus.res_data), 64'(q[0].sum));
      check_val("res_cout", 64'(bus.res_cout), 64'(q[0].cout));
      check_val("res_id",   64'(bus.res_id),   64'(q[0].id));
    end
    check_val("inflight", 64'(bus.inflight), 64'(q.size()));
    @(posedge clock0);
    if (head_ok && rr) void'(q.pop_front());
    if (adv) begin
      foreach (q[i]) q[i].age = q[i].age + 8'd1;
    end
    if (g >= 0) begin
      s      = {1'b0, a[g*WIDTH +: WIDTH]} + {1'b0, b[g*WIDTH +: WIDTH]};
      n.sum  = s[WIDTH-1:0];
      n.cout = s[WIDTH];
      n.id   = IDW'(g);
      n.age  = 8'd1;
      q.push_back(n);
`ifndef ADDER_ARB_FIXED_PRIO_EN
      ptr_m = (g + 1) % NUM_REQ;
`endif
    end
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) drive('0, '0, '0, 1'b1);
  endtask

  // Asynchronous reset pulse in the middle of a cycle; model forgets everything.
  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    reset = 1'b0;
    #2;
    check_val("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check_val("rst_res_data",  64'(bus.res_data),  64'd0);
    check_val("rst_res_cout",  64'(bus.res_cout),  64'd0);
    check_val("rst_res_id",    64'(bus.res_id),    64'd0);
    check_val("rst_inflight",  64'(bus.inflight),  64'd0);
    q.delete();
    ptr_m = 0;
    @(posedge clock0);
    @(negedge clock0);
    reset = 1'b1;
    @(posedge clock0);
    #1;
  endtask

  logic [NUM_REQ*WIDTH-1:0] a_v, b_v;
  logic [NUM_REQ-1:0]       exp_g;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    last_rdy      = '0;
    #3;
    do_reset();

    // Single op from requester 2: 100 + 23.
    a_v = '0; b_v = '0;
    a_v[2*WIDTH +: WIDTH] = 26'd100;
    b_v[2*WIDTH +: WIDTH] = 26'd23;
    drive(4'b0100, a_v, b_v, 1'b1);
    idle(LAT + 1);

    // Overflow cases from requester 0.
    a_v = '0; b_v = '0;
    a_v[0 +: WIDTH] = 26'h3FFFFFF;
    b_v[0 +: WIDTH] = 26'h0000001;
    drive(4'b0001, a_v, b_v, 1'b1);
    a_v[0 +: WIDTH] = 26'h2000000;
    b_v[0 +: WIDTH] = 26'h2000000;
    drive(4'b0001, a_v, b_v, 1'b1);
    idle(LAT + 1);

    // Three ops in flight, then reset mid-stream.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NUM_REQ*WIDTH; i += 32) begin
        a_v[i +: 32] = $urandom;
        b_v[i +: 32] = $urandom;
      end
      drive(4'b1111, a_v, b_v, 1'b1);
    end
    do_reset();
    idle(2);

    // All requesters held high for 8 cycles.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NUM_REQ*WIDTH; i += 32) begin
        a_v[i +: 32] = $urandom;
        b_v[i +: 32] = $urandom;
      end
      drive(4'b1111, a_v, b_v, 1'b1);
`ifdef ADDER_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (c % NUM_REQ);
`endif
      check_val("rr_grant_seq", 64'(last_rdy), 64'(exp_g));
    end

    // Backpressure: pipe is full, stall 5 cycles, then drain.
    for (int c = 0; c < 5; c++) drive(4'b1111, a_v, b_v, 1'b0);
    check_val("bp_inflight", 64'(bus.inflight), 64'(LAT));
    idle(LAT + 3);

    // Sparse: requester 3 every third cycle.
    for (int c = 0; c < 12; c++) begin
      a_v = '0; b_v = '0;
      a_v[3*WIDTH +: WIDTH] = WIDTH'($urandom);
      b_v[3*WIDTH +: WIDTH] = WIDTH'($urandom);
      drive((c % 3 == 0) ? 4'b1000 : 4'b0000, a_v, b_v, 1'b1);
    end
    idle(LAT + 1);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ*WIDTH; i += 32) begin
        a_v[i +: 32] = $urandom;
        b_v[i +: 32] = $urandom;
      end
      drive(NUM_REQ'($urandom), a_v, b_v, ($urandom_range(3, 0) != 0));
    end
    idle(LAT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
